command_fetch: RTL and testbench

COMMAND_FETCH -- requirements
Module: command_fetch

---
 rtl/command_fetch_pkg.sv | 19 +
 rtl/command_fetch_fifo.sv | 74 +++++++
 rtl/command_fetch.sv | 120 ++++++++++++
 tb/tb_command_fetch.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/command_fetch_pkg.sv
// Shared definitions for the command fetch block.
// Holds the default RAM geometry (word width, address width, word count)
// and the state type used by the fetch controller.
package command_fetch_pkg;

    localparam int CF_DATA_W = 32;
    localparam int CF_ADDR_W = 9;
    localparam int CF_DEPTH  = 400;

    // Explicit encodings so the state register reads the same as older
    // revisions of this block in a waveform viewer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/command_fetch_fifo.sv
// fetch_fifo: three-entry output buffer for the command fetcher.
// Ports:
//   clk, n_rst         clock, synchronous active-low reset (empties buffer)
//   push, wr_data      write a word at the tail
//   pop                remove the head word (ignored when empty)
//   rd_data            head word (meaningless while empty)
//   occupancy          number of stored words, 0..3
//   empty, full        occupancy == 0 / occupancy == 3
// Entries are plain registers so the head is visible in the same cycle it
// is written into the buffer's head slot, without a read-latency stage.
module fetch_fifo
    import command_fetch_pkg::*;
#(
    parameter int DATA_W = CF_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        occupancy,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_reg [0:2];
    logic [1:0]        wr_ptr_reg;
    logic [1:0]        rd_ptr_reg;
    logic [1:0]        occ_reg;
    logic              push_ok;
    logic              pop_ok;

    assign empty     = (occ_reg == 2'd0);
    assign full      = (occ_reg == 2'd3);
    assign occupancy = occ_reg;
    assign rd_data   = mem_reg[rd_ptr_reg];

    // A push into a full buffer is only legal when the head leaves the
    // same cycle; ordering is preserved because pointers move independently.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == 2'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            occ_reg    <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == 2'd2) ? 2'd0 : wr_ptr_reg + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == 2'd2) ? 2'd0 : rd_ptr_reg + 2'd1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/command_fetch.sv
// command_fetch: reads a burst of words from an external synchronous RAM
// and streams them out through a valid/ready interface.
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   start, base_addr, count burst request, sampled only while idle
//   read_address, q         RAM read port (q valid one cycle after address)
//   out_data, out_valid,
//   out_ready               output stream, transfer when valid && ready
//   busy                    burst in progress (through the done cycle)
//   done                    single-cycle completion pulse
module command_fetch
    import command_fetch_pkg::*;
#(
    parameter int DATA_W = CF_DATA_W,
    parameter int ADDR_W = CF_ADDR_W,
    parameter int DEPTH  = CF_DEPTH
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] remain_reg, remain_next;
    logic              inflight_reg;
    logic              issue;
    logic              pop_fire;
    logic [1:0]        fifo_occ;
    logic              fifo_empty;
    logic              fifo_full;

    fetch_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (inflight_reg),
        .pop       (pop_fire),
        .wr_data   (q),
        .rd_data   (out_data),
        .occupancy (fifo_occ),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid    = !fifo_empty;
    assign pop_fire     = out_valid && out_ready;
    assign read_address = addr_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign done         = (state_reg == ST_DONE);

    // Issue decision uses only registered occupancy and the in-flight bit,
    // so out_ready never reaches read_address combinationally. Keeping
    // stored + in-flight below three guarantees every returning word has
    // a free slot.
    assign issue = (state_reg == ST_FETCH) &&
                   (({1'b0, fifo_occ} + {2'b00, inflight_reg}) < 3'd3);

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    addr_next   = base_addr;
                    remain_next = count;
                    state_next  = (count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    // Wrap at the end of the RAM, not at the address width.
                    addr_next   = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
                    remain_next = remain_reg - 1'b1;
                    if (remain_reg == ADDR_W'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last word leaves when nothing is in flight and it is the
                // only word still buffered.
                if (pop_fire && !inflight_reg && (fifo_occ == 2'd1)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            remain_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            remain_reg   <= remain_next;
            inflight_reg <= issue;
        end
    end

endmodule

// File: tb/tb_command_fetch.sv
module tb_command_fetch;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 400;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] ram [0:511];

    int tests_run = 0;
    int tests_failed = 0;

    command_fetch #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .read_address (read_address),
        .q            (q),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // External synchronous RAM: data one cycle after the address.
    always @(posedge clk) q <= ram[read_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: toggle + 5-cycle stall,
    // 3: random ready plus a second start mid-burst.
    // abort_after >= 0: reset right after that many words have transferred.
    task automatic run_burst(input int base, input int cnt, input int mode, input int abort_after);
        logic [31:0] exp_q[$];
        int  cyc, xfers, done_cnt, last_xfer_cyc, exp_done_cyc;
        bit  finished, aborted, abort_pending, prev_stall, xfer;
        logic [31:0] prev_data;
        for (int i = 0; i < cnt; i++) exp_q.push_back(ram[(base + i) % DEPTH]);
        cyc = 0; xfers = 0; done_cnt = 0; last_xfer_cyc = 0;
        finished = 0; aborted = 0; abort_pending = 0; prev_stall = 0; prev_data = '0;

        @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(base); count = ADDR_W'(cnt);
        out_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        count = ADDR_W'($urandom_range(0, DEPTH));

        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (abort_pending) begin
                n_rst = 1'b0; out_ready = 1'b0;
                @(posedge clk); @(negedge clk);
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_addr", 32'(read_address), 32'd0);
                n_rst = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("abort_no_done", 32'(done), 32'd0);
                end
                aborted = 1; finished = 1;
            end else begin
                if (mode == 3) begin
                    if (cyc == 2) begin
                        start = 1'b1;
                        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                        count = ADDR_W'($urandom_range(1, 20));
                    end else begin
                        start = 1'b0;
                    end
                end
                if (mode == 0 && cyc <= cnt)
                    check("rd_addr", 32'(read_address), 32'((base + cyc - 1) % DEPTH));
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, prev_data);
                end
                check("busy", 32'(busy), 32'd1);
                if (cnt == 0) check("valid_cnt0", 32'(out_valid), 32'd0);
                if (done) begin
                    done_cnt++;
                    exp_done_cyc = (cnt == 0) ? 1 : last_xfer_cyc + 1;
                    check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
                    check("word_count", 32'(xfers), 32'(cnt));
                    finished = 1;
                end else begin
                    case (mode)
                        0:       out_ready = 1'b1;
                        2:       out_ready = (cyc >= 6 && cyc <= 10) ? 1'b0 : 1'(cyc % 2);
                        default: out_ready = 1'($urandom_range(0, 1));
                    endcase
                    xfer = out_valid && out_ready;
                    if (xfer) begin
                        if (exp_q.size() == 0) begin
                            check("extra_word", 32'(xfers + 1), 32'(cnt));
                        end else begin
                            check("data", out_data, exp_q.pop_front());
                        end
                        if (mode == 0) check("xfer_cycle", 32'(cyc), 32'(3 + xfers));
                        xfers++;
                        last_xfer_cyc = cyc;
                        if (abort_after >= 0 && xfers == abort_after) abort_pending = 1;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_data = out_data;
                end
            end
        end
        if (!aborted) begin
            check("timeout_done", 32'(done_cnt), 32'd1);
            @(negedge clk);
            check("busy_after", 32'(busy), 32'd0);
            check("done_after", 32'(done), 32'd0);
            check("valid_after", 32'(out_valid), 32'd0);
        end
        $display("[TB] burst base=%0d count=%0d mode=%0d words=%0d abort=%0d", base, cnt, mode, xfers, aborted);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = $urandom;
        ram[10] = 32'h0000_000A;
        ram[11] = 32'h0000_000B;
        ram[12] = 32'h0000_000C;
        ram[13] = 32'h0000_000D;

        n_rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", 32'(read_address), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        run_burst(10, 4, 0, -1);
        run_burst(398, 4, 0, -1);
        run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 2, -1);
        run_burst(50, 0, 0, -1);
        run_burst(100, 7, 3, -1);
        run_burst(200, 6, 0, 2);
        run_burst(300, 5, 0, -1);
        run_burst(395, 10, 1, -1);
        for (int r = 0; r < 6; r++)
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 12)), 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
